// File: rtl/alu4_pkg.sv
// Shared constants for the 4-bit ALU/accumulator block.
// Holds the opcode encodings, FSM state type and flag bit positions.
package alu4_pkg;

  localparam int ALU_WIDTH = 4;

  localparam logic [2:0] OP_NOT_A = 3'b000;
  localparam logic [2:0] OP_NOT_B = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_XNOR  = 3'b101;
  localparam logic [2:0] OP_ADD   = 3'b110;
  localparam logic [2:0] OP_SUB   = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_FULL = 2'b10
  } state_e;

endpackage

// File: rtl/alu4.sv
// Purely combinational ALU datapath: logic ops plus modulo-2^WIDTH add/sub.
// Produces the result and the arithmetic flags C and V; N/Z live in the wrapper.
module alu4
  import alu4_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             v
);

  logic [WIDTH:0] sum;

  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    sum    = '0;
    case (op)
      OP_NOT_A: result = ~a;
      OP_NOT_B: result = ~b;
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_XNOR:  result = ~(a ^ b);
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Carry out of A + ~B + 1 is the "no borrow" indication (A >= B unsigned).
        sum    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu4_acc.sv
// ALU with accumulator and a valid/ready handshake on both sides.
// One operation in flight: IDLE accepts, EXEC computes, FULL holds the result.
module alu4_acc
  import alu4_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_acc,
  input  logic             clr_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [WIDTH-1:0] acc
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] alu_result;
  logic             alu_c;
  logic             alu_v;

  alu4 #(.WIDTH(WIDTH)) u_alu (
    .a      (opa_q),
    .b      (opb_q),
    .op     (op_q),
    .result (alu_result),
    .c      (alu_c),
    .v      (alu_v)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    result_d    = result_q;
    flags_d     = flags_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A clear takes the whole cycle, so it also blocks acceptance.
        in_ready = reset_n & ~clr_acc;
        if (clr_acc) begin
          acc_d = '0;
        end else if (in_valid) begin
          op_d    = op;
          opa_d   = a;
          opb_d   = use_acc ? acc_q : b;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d         = alu_result;
        flags_d[FLAG_N]  = alu_result[WIDTH-1];
        flags_d[FLAG_Z]  = (alu_result == '0);
        flags_d[FLAG_C]  = alu_c;
        flags_d[FLAG_V]  = alu_v;
        acc_d            = alu_result;
        out_valid_d      = 1'b1;
        state_d          = ST_FULL;
      end
      ST_FULL: begin
        if (clr_acc) begin
          acc_d = '0;
        end
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_alu4_acc.sv
// Self-checking bench for alu4_acc: directed vector table, hand-written
// handshake/accumulator/reset sequences, and randomized ops against a model.
module tb_alu4_acc;
  import alu4_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic       use_acc;
  logic       clr_acc;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] result;
  logic [3:0] flags;
  logic [3:0] acc;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu4_acc #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .use_acc   (use_acc),
    .clr_acc   (clr_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .acc       (acc)
  );

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_result;
    logic [3:0] exp_flags;
    string      name;
  } vec_t;

  vec_t vec_table[$];

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference model from the arithmetic definitions, returns {result, N Z C V}.
  function automatic logic [7:0] refModel(input logic [2:0] op_i, input logic [3:0] a_i, input logic [3:0] b_i);
    int ua, ub, sa, sb, r;
    logic [3:0] res;
    logic c_f, v_f;
    ua  = int'(a_i);
    ub  = int'(b_i);
    sa  = (ua > 7) ? ua - 16 : ua;
    sb  = (ub > 7) ? ub - 16 : ub;
    c_f = 1'b0;
    v_f = 1'b0;
    r   = 0;
    case (op_i)
      3'b000: res = ~a_i;
      3'b001: res = ~b_i;
      3'b010: res = a_i & b_i;
      3'b011: res = a_i | b_i;
      3'b100: res = a_i ^ b_i;
      3'b101: res = ~(a_i ^ b_i);
      3'b110: begin
        r   = (ua + ub) % 16;
        res = 4'(r);
        c_f = (ua + ub) > 15;
        v_f = (sa + sb > 7) || (sa + sb < -8);
      end
      default: begin
        r   = (ua - ub + 16) % 16;
        res = 4'(r);
        c_f = ua >= ub;
        v_f = (sa - sb > 7) || (sa - sb < -8);
      end
    endcase
    return {res, res[3], (res == 4'h0), c_f, v_f};
  endfunction

  // Full transaction: accept, EXEC, FULL (optionally stalled), drain.
  task automatic applyStimulus(input logic [2:0] op_i, input logic [3:0] a_i, input logic [3:0] b_i,
                               input logic ua_i, input logic [3:0] exp_res, input logic [3:0] exp_flags,
                               input int stall, input string name);
    int waited = 0;
    @(negedge clk);
    op = op_i; a = a_i; b = b_i; use_acc = ua_i; in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 10) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput($sformatf("%s/in_ready", name), 8'(in_ready), 8'h1);
    @(negedge clk);
    in_valid = 1'b0;
    a = 4'($urandom);
    b = 4'($urandom);
    checkOutput($sformatf("%s/exec_out_valid", name), 8'(out_valid), 8'h0);
    @(negedge clk);
    checkOutput($sformatf("%s/out_valid", name), 8'(out_valid), 8'h1);
    checkOutput($sformatf("%s/result", name), 8'(result), 8'(exp_res));
    checkOutput($sformatf("%s/flags", name), 8'(flags), 8'(exp_flags));
    checkOutput($sformatf("%s/acc", name), 8'(acc), 8'(exp_res));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      a = 4'($urandom);
      #1;
      checkOutput($sformatf("%s/stall_in_ready", name), 8'(in_ready), 8'h0);
      @(negedge clk);
      checkOutput($sformatf("%s/stall_valid", name), 8'(out_valid), 8'h1);
      checkOutput($sformatf("%s/stall_result", name), {result, flags}, {exp_res, exp_flags});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput($sformatf("%s/drained", name), 8'(out_valid), 8'h0);
  endtask

  task automatic clearAcc(input logic [3:0] keep_result, input logic [3:0] keep_flags, input string name);
    @(negedge clk);
    clr_acc = 1'b1;
    #1;
    checkOutput($sformatf("%s/clr_in_ready", name), 8'(in_ready), 8'h0);
    @(negedge clk);
    clr_acc = 1'b0;
    checkOutput($sformatf("%s/clr_acc", name), 8'(acc), 8'h0);
    checkOutput($sformatf("%s/clr_keeps", name), {result, flags}, {keep_result, keep_flags});
  endtask

  initial begin
    logic [7:0] exp;
    logic [3:0] acc_m;
    logic [3:0] ra, rb;
    logic [2:0] rop;
    logic       ruse;

    reset_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
    use_acc = 1'b0; clr_acc = 1'b0; out_ready = 1'b0;

    vec_table.push_back('{OP_ADD,   4'h7, 4'h1, 4'h8, 4'b1001, "add_ovf"});
    vec_table.push_back('{OP_SUB,   4'h3, 4'h5, 4'he, 4'b1000, "sub_neg"});
    vec_table.push_back('{OP_SUB,   4'h5, 4'h5, 4'h0, 4'b0110, "sub_zero"});
    vec_table.push_back('{OP_AND,   4'hc, 4'ha, 4'h8, 4'b1000, "and"});
    vec_table.push_back('{OP_OR,    4'h0, 4'h0, 4'h0, 4'b0100, "or_zero"});
    vec_table.push_back('{OP_XOR,   4'hf, 4'h5, 4'ha, 4'b1000, "xor"});
    vec_table.push_back('{OP_XNOR,  4'hf, 4'h5, 4'h5, 4'b0000, "xnor"});
    vec_table.push_back('{OP_NOT_A, 4'hf, 4'h2, 4'h0, 4'b0100, "not_a"});
    vec_table.push_back('{OP_NOT_B, 4'h1, 4'h3, 4'hc, 4'b1000, "not_b"});
    vec_table.push_back('{OP_ADD,   4'hf, 4'h1, 4'h0, 4'b0110, "add_wrap"});
    vec_table.push_back('{OP_SUB,   4'h8, 4'h1, 4'h7, 4'b0011, "sub_ovf"});
    vec_table.push_back('{OP_ADD,   4'h8, 4'h8, 4'h0, 4'b0111, "add_neg_ovf"});

    #2;
    checkOutput("reset_outputs", {result, flags}, 8'h00);
    checkOutput("reset_acc_valid", {acc, 3'b000, out_valid}, 8'h00);
    checkOutput("reset_in_ready", 8'(in_ready), 8'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("post_reset_in_ready", 8'(in_ready), 8'h1);

    foreach (vec_table[i])
      applyStimulus(vec_table[i].op, vec_table[i].a, vec_table[i].b, 1'b0,
                    vec_table[i].exp_result, vec_table[i].exp_flags, 0, vec_table[i].name);

    // Long backpressure: FULL must hold and ignore new requests.
    applyStimulus(OP_SUB, 4'h3, 4'h5, 1'b0, 4'he, 4'b1000, 5, "stall5");
    @(negedge clk);
    checkOutput("stall5/no_ghost", 8'(out_valid), 8'h0);

    // Accumulation chain from zero.
    clearAcc(4'he, 4'b1000, "acc_init");
    applyStimulus(OP_ADD, 4'h3, 4'h0, 1'b1, 4'h3, 4'b0000, 0, "acc1");
    applyStimulus(OP_ADD, 4'h3, 4'h0, 1'b1, 4'h6, 4'b0000, 0, "acc2");
    applyStimulus(OP_ADD, 4'h3, 4'h0, 1'b1, 4'h9, 4'b1001, 1, "acc3");
    clearAcc(4'h9, 4'b1001, "acc_clr");

    // Clear and request together: clear wins, request taken next cycle.
    applyStimulus(OP_ADD, 4'h3, 4'h4, 1'b0, 4'h7, 4'b0000, 0, "preload");
    @(negedge clk);
    clr_acc = 1'b1; in_valid = 1'b1; op = OP_ADD; a = 4'h1; b = 4'h9; use_acc = 1'b1;
    #1;
    checkOutput("clr_req/in_ready_low", 8'(in_ready), 8'h0);
    @(negedge clk);
    checkOutput("clr_req/acc", 8'(acc), 8'h0);
    checkOutput("clr_req/not_started", 8'(out_valid), 8'h0);
    clr_acc = 1'b0;
    #1;
    checkOutput("clr_req/in_ready_high", 8'(in_ready), 8'h1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("clr_req/exec", 8'(out_valid), 8'h0);
    @(negedge clk);
    checkOutput("clr_req/valid", 8'(out_valid), 8'h1);
    checkOutput("clr_req/result", {result, acc}, 8'h11);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Clear during EXEC is overridden by the write-back.
    @(negedge clk);
    in_valid = 1'b1; op = OP_ADD; a = 4'h1; b = 4'h5; use_acc = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; clr_acc = 1'b1;
    @(negedge clk);
    clr_acc = 1'b0;
    checkOutput("clr_exec/acc", 8'(acc), 8'h6);
    // Clear during FULL zeroes acc but keeps the held result.
    clr_acc = 1'b1;
    @(negedge clk);
    clr_acc = 1'b0;
    checkOutput("clr_full/acc", 8'(acc), 8'h0);
    checkOutput("clr_full/held", {result, flags}, 8'h60);
    checkOutput("clr_full/valid", 8'(out_valid), 8'h1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Randomized ops with accumulator tracking.
    acc_m = 4'h0;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(7) == 0) begin
        clearAcc(result, flags, "rand_clr");
        acc_m = 4'h0;
      end
      rop  = 3'($urandom);
      ra   = 4'($urandom);
      rb   = 4'($urandom);
      ruse = 1'($urandom);
      exp  = refModel(rop, ra, ruse ? acc_m : rb);
      applyStimulus(rop, ra, rb, ruse, exp[7:4], exp[3:0], int'($urandom_range(2)),
                    $sformatf("rand%0d_op%0d", n, rop));
      acc_m = exp[7:4];
    end

    // Reset while an operation is in EXEC aborts it.
    @(negedge clk);
    in_valid = 1'b1; op = OP_ADD; a = 4'h5; b = 4'h2; use_acc = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_exec/result_flags", {result, flags}, 8'h00);
    checkOutput("rst_exec/acc", 8'(acc), 8'h0);
    checkOutput("rst_exec/valid_ready", {out_valid, in_ready}, 8'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_exec/no_result", 8'(out_valid), 8'h0);
    end
    checkOutput("rst_exec/in_ready", 8'(in_ready), 8'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
